// File: rtl/mac_pipe.sv
// Pipelined signed/unsigned multiply-accumulate with first/last burst framing,
// sticky overflow and output backpressure. Define MAC_SATURATE_EN to clamp on overflow.
module mac_pipe #(
    parameter int WIDTH_A      = 16,
    parameter int WIDTH_B      = 16,
    parameter int NB_EXTRA_REG = 1,
    parameter int ACC_WIDTH    = 40
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic                 first,
    input  logic                 last,
    input  logic [WIDTH_A-1:0]   a,
    input  logic [WIDTH_B-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out,
    output logic                 out_ovf
);
    // Handshake: a beat moves on any edge where valid and ready are both high;
    // ready never depends on valid. One global advance freezes the whole pipe
    // while a result is held unconsumed.
    localparam int P  = NB_EXTRA_REG + 1;
    // P product stages plus one alignment register ahead of the accumulator,
    // giving a last-to-result latency of P+1 edges.
    localparam int NS = P + 1;
    localparam int PW = WIDTH_A + WIDTH_B;
    localparam int M  = ACC_WIDTH - 1;

    logic                 adv;
    logic [PW-1:0]        prod_d [NS];
    logic [PW-1:0]        prod_q [NS];
    logic [NS-1:0]        vld_d, vld_q, fst_d, fst_q, lst_d, lst_q, sgn_d, sgn_q;
    logic [ACC_WIDTH-1:0] acc_d, acc_q, out_d, out_q;
    logic                 ovf_d, ovf_q, out_valid_d, out_valid_q, out_ovf_d, out_ovf_q;
    logic [PW-1:0]        prod_u, prod_s;
    logic [ACC_WIDTH-1:0] ext, sum, sat_sum, new_acc;
    logic [ACC_WIDTH:0]   sum_full;
    logic                 ovf_now, new_ovf;

    assign adv       = ~out_valid_q | out_ready;
    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        prod_u = {{WIDTH_B{1'b0}}, a} * {{WIDTH_A{1'b0}}, b};
        prod_s = $signed({{WIDTH_B{a[WIDTH_A-1]}}, a}) * $signed({{WIDTH_A{b[WIDTH_B-1]}}, b});
    end

    always_comb begin
        prod_d = prod_q;
        vld_d  = vld_q;
        fst_d  = fst_q;
        lst_d  = lst_q;
        sgn_d  = sgn_q;
        if (adv) begin
            vld_d[0]  = in_valid;
            fst_d[0]  = first;
            lst_d[0]  = last;
            sgn_d[0]  = is_signed;
            prod_d[0] = is_signed ? prod_s : prod_u;
            for (int i = 1; i < NS; i++) begin
                vld_d[i]  = vld_q[i-1];
                fst_d[i]  = fst_q[i-1];
                lst_d[i]  = lst_q[i-1];
                sgn_d[i]  = sgn_q[i-1];
                prod_d[i] = prod_q[i-1];
            end
        end
    end

    always_comb begin
        if (sgn_q[NS-1]) begin
            ext = ACC_WIDTH'($signed(prod_q[NS-1]));
        end else begin
            ext = ACC_WIDTH'(prod_q[NS-1]);
        end
        sum_full = {1'b0, acc_q} + {1'b0, ext};
        sum      = sum_full[M:0];
        // Each beat applies its own overflow rule, so mixed-mode bursts are well defined.
        if (sgn_q[NS-1]) begin
            ovf_now = (acc_q[M] == ext[M]) && (sum[M] != acc_q[M]);
        end else begin
            ovf_now = sum_full[ACC_WIDTH];
        end
`ifdef MAC_SATURATE_EN
        if (ovf_now) begin
            if (sgn_q[NS-1]) begin
                sat_sum = acc_q[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
            end else begin
                sat_sum = '1;
            end
        end else begin
            sat_sum = sum;
        end
`else
        sat_sum = sum;
`endif
        new_acc = fst_q[NS-1] ? ext  : sat_sum;
        new_ovf = fst_q[NS-1] ? 1'b0 : (ovf_q | ovf_now);
    end

    always_comb begin
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_d       = out_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        if (adv) begin
            out_valid_d = 1'b0;
            if (vld_q[NS-1]) begin
                acc_d = new_acc;
                ovf_d = new_ovf;
                if (lst_q[NS-1]) begin
                    out_d       = new_acc;
                    out_ovf_d   = new_ovf;
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                prod_q[i] <= '0;
            end
            vld_q       <= '0;
            fst_q       <= '0;
            lst_q       <= '0;
            sgn_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            out_q       <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            vld_q       <= vld_d;
            fst_q       <= fst_d;
            lst_q       <= lst_d;
            sgn_q       <= sgn_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            out_q       <= out_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: a 40-bit and a 32-bit accumulator instance share
// one stimulus stream; expected results are hand-computed (MAC_SATURATE_EN aware).
module tb_mac_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, is_signed, first, last, out_ready;
    logic [15:0] a, b;
    logic        in_ready, in_ready32, out_valid, out_valid32, out_ovf, out_ovf32;
    logic [39:0] out;
    logic [31:0] out32;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        bp_done;

    typedef struct packed {
        logic [39:0] v40;
        logic        o40;
        logic [31:0] v32;
        logic        o32;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mac_pipe #(.WIDTH_A(16), .WIDTH_B(16), .NB_EXTRA_REG(1), .ACC_WIDTH(40)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .is_signed(is_signed), .first(first), .last(last), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_ovf(out_ovf)
    );

    mac_pipe #(.WIDTH_A(16), .WIDTH_B(16), .NB_EXTRA_REG(1), .ACC_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
        .is_signed(is_signed), .first(first), .last(last), .a(a), .b(b),
        .out_valid(out_valid32), .out_ready(out_ready), .out(out32), .out_ovf(out_ovf32)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_res(input logic [39:0] v40, input logic o40,
                              input logic [31:0] v32, input logic o32);
        exp_t e;
        e.v40 = v40;
        e.o40 = o40;
        e.v32 = v32;
        e.o32 = o32;
        exp_q.push_back(e);
    endtask

    // Called just after a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [15:0] ta, input logic [15:0] tb,
                        input logic ts, input logic tf, input logic tl);
        int w;
        a = ta;
        b = tb;
        is_signed = ts;
        first = tf;
        last = tl;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("accept_wait", 64'(w < 200), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("drain", 64'(exp_q.size()), 0);
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 out_ready = r;
    endtask

    // Scoreboard: every consumed result must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            check("have_exp", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("out40", 64'(out), 64'(e.v40));
                check("ovf40", 64'(out_ovf), 64'(e.o40));
                check("valid32", 64'(out_valid32), 1);
                check("out32", 64'(out32), 64'(e.v32));
                check("ovf32", 64'(out_ovf32), 64'(e.o32));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0;
        is_signed = 1'b0;
        first = 1'b0;
        last = 1'b0;
        a = '0;
        b = '0;
        out_ready = 1'b1;
        bp_done = 1'b0;

        #3;
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_out", 64'(out), 0);
        check("rst_out_ovf", 64'(out_ovf), 0);
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_out_valid32", 64'(out_valid32), 0);
        #19 rst_n = 1'b1;
        @(negedge clk);

        // Unsigned burst with latency and single-cycle valid.
        expect_res(40'd92, 1'b0, 32'd92, 1'b0);
        send(16'd3, 16'd5, 1'b0, 1'b1, 1'b0);
        send(16'd7, 16'd11, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 3);
        @(negedge clk);
        check("valid_one_cycle", 64'(out_valid), 0);

        // Signed single beat: -2 * 3.
        expect_res(40'hFFFFFFFFFA, 1'b0, 32'hFFFFFFFA, 1'b0);
        send(16'hFFFE, 16'h0003, 1'b1, 1'b1, 1'b1);

        // Signed burst: -100*200 + 50*50 + (-1)*(-1) = -17499.
        expect_res(40'hFFFFFFBBA5, 1'b0, 32'hFFFFBBA5, 1'b0);
        send(16'hFF9C, 16'h00C8, 1'b1, 1'b1, 1'b0);
        send(16'h0032, 16'h0032, 1'b1, 1'b0, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1);

        // A first mid-burst drops the running sum: 1 + 6.
        expect_res(40'd7, 1'b0, 32'd7, 1'b0);
        send(16'd10, 16'd10, 1'b0, 1'b1, 1'b0);
        send(16'd1, 16'd1, 1'b0, 1'b1, 1'b0);
        send(16'd2, 16'd3, 1'b0, 1'b0, 1'b1);

`ifdef MAC_SATURATE_EN
        expect_res(40'h01FFFC0002, 1'b0, 32'hFFFFFFFF, 1'b1);
`else
        expect_res(40'h01FFFC0002, 1'b0, 32'hFFFC0002, 1'b1);
`endif
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);

        // Four signed 2^30 beats.
`ifdef MAC_SATURATE_EN
        expect_res(40'h0100000000, 1'b0, 32'h7FFFFFFF, 1'b1);
`else
        expect_res(40'h0100000000, 1'b0, 32'h00000000, 1'b1);
`endif
        send(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0);
        send(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1);

        // Mixed modes: signed -1 then unsigned +1 carries out of the top bit.
`ifdef MAC_SATURATE_EN
        expect_res(40'hFFFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);
`else
        expect_res(40'h0, 1'b1, 32'h0, 1'b1);
`endif
        send(16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0);
        send(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
        wait_drain();

        // Backpressure: held result, five more beats queued behind it.
        set_ready(1'b0);
        @(negedge clk);
        expect_res(40'd20, 1'b0, 32'd20, 1'b0);
        send(16'd4, 16'd5, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_result_ready", 64'(out_valid), 1);
        for (int i = 1; i <= 5; i++) begin
            expect_res(40'(i * i), 1'b0, 32'(i * i), 1'b0);
        end
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    send(16'(i), 16'(i), 1'b0, 1'b1, 1'b1);
                end
                bp_done = 1'b1;
            end
        join_none
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 0);
            check("bp_out_hold", 64'(out), 20);
            check("bp_valid_hold", 64'(out_valid), 1);
        end
        set_ready(1'b1);
        for (int k = 0; k < 12; k++) begin
            set_ready(1'($urandom_range(0, 1)));
        end
        set_ready(1'b1);
        n = 0;
        while (!bp_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_sender_done", 64'(bp_done), 1);
        wait_drain();

        // Reset with a pending result and a partial burst in flight.
        set_ready(1'b0);
        @(negedge clk);
        send(16'd9, 16'd9, 1'b0, 1'b1, 1'b1);
        send(16'd3, 16'd4, 1'b0, 1'b1, 1'b0);
        send(16'd5, 16'd6, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_valid", 64'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 0);
        check("mid_rst_out", 64'(out), 0);
        check("mid_rst_ovf", 64'(out_ovf), 0);
        check("mid_rst_valid32", 64'(out_valid32), 0);
        #10;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        expect_res(40'd4, 1'b0, 32'd4, 1'b0);
        send(16'd2, 16'd2, 1'b0, 1'b1, 1'b1);
        wait_drain();
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
